// File: rtl/time_entry_fsm_if.sv
// Key input and entry/commit output bundle between the key decoder, the
// time-entry FSM and the timekeeping/alarm registers.
interface time_entry_fsm_if;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        entry_active;
  logic        entry_target;
  logic [15:0] entry_digits;
  logic [2:0]  entry_count;
  logic        set_time;
  logic        set_alarm;
  logic [15:0] commit_hhmm;
  logic        entry_err;

  modport master (
    output key_code, key_valid,
    input  entry_active, entry_target, entry_digits, entry_count,
    input  set_time, set_alarm, commit_hhmm, entry_err
  );

  modport slave (
    input  key_code, key_valid,
    output entry_active, entry_target, entry_digits, entry_count,
    output set_time, set_alarm, commit_hhmm, entry_err
  );
endinterface

// File: rtl/time_entry_fsm.sv
// HH:MM entry assembler: collects range-checked BCD digits after a T/A key and
// commits them as a one-cycle set_time/set_alarm pulse on Enter.
module time_entry_fsm #(
  parameter int TIMEOUT_CYCLES = 1_000_000_000,
  parameter int TMR_W          = 30
) (
  input  logic            CLK100MHZ,
  input  logic            reset,
  time_entry_fsm_if.slave bus
);
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_BKSP = 4'hD;
  localparam logic [3:0] KEY_ENT  = 4'hE;

  typedef enum logic [0:0] {IDLE, ENTRY} state_t;

  state_t             state_q, state_d;
  logic               target_q, target_d;
  logic [15:0]        digits_q, digits_d;
  logic [2:0]         count_q, count_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [15:0]        commit_q, commit_d;
  logic               set_time_q, set_time_d;
  logic               set_alarm_q, set_alarm_d;
  logic               err_q, err_d;

  logic [3:0] code;
  logic       is_digit;
  logic       digit_ok;
  logic [1:0] wr_idx;
  logic [1:0] bk_idx;

  assign code     = bus.key_code;
  assign is_digit = (code <= 4'd9);
  assign wr_idx   = count_q[1:0];
  assign bk_idx   = count_q[1:0] - 2'd1;

  // Range check for the next position; p1 depends on the H-tens already held.
  always_comb begin
    digit_ok = 1'b0;
    case (count_q)
      3'd0:    digit_ok = (code <= 4'd2);
      3'd1:    digit_ok = is_digit && ((digits_q[15:12] != 4'd2) || (code <= 4'd3));
      3'd2:    digit_ok = (code <= 4'd5);
      3'd3:    digit_ok = is_digit;
      default: digit_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    digits_d    = digits_q;
    count_d     = count_q;
    tmr_d       = tmr_q;
    commit_d    = commit_q;
    set_time_d  = 1'b0;
    set_alarm_d = 1'b0;
    err_d       = 1'b0;

    case (state_q)
      IDLE: begin
        tmr_d = '0;
        if (bus.key_valid && (code == KEY_A || code == KEY_B)) begin
          state_d  = ENTRY;
          target_d = (code == KEY_A);
          digits_d = '0;
          count_d  = '0;
        end
      end

      ENTRY: begin
        if (bus.key_valid) begin
          // Any key, even an ignored one, restarts the idle timer.
          tmr_d = '0;
          if (is_digit) begin
            if (count_q != 3'd4 && digit_ok) begin
              digits_d[{2'd3 - wr_idx, 2'b00} +: 4] = code;
              count_d = count_q + 3'd1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            case (code)
              KEY_A, KEY_B: begin
                target_d = (code == KEY_A);
                digits_d = '0;
                count_d  = '0;
              end
              KEY_BKSP: begin
                if (count_q == 3'd0) begin
                  state_d  = IDLE;
                  digits_d = '0;
                end else begin
                  count_d = count_q - 3'd1;
                  digits_d[{2'd3 - bk_idx, 2'b00} +: 4] = 4'd0;
                end
              end
              KEY_ENT: begin
                if (count_q == 3'd4) begin
                  commit_d    = digits_q;
                  set_time_d  = ~target_q;
                  set_alarm_d = target_q;
                  state_d     = IDLE;
                  digits_d    = '0;
                  count_d     = '0;
                end else begin
                  err_d = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end else if (tmr_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          state_d  = IDLE;
          digits_d = '0;
          count_d  = '0;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q     <= IDLE;
      target_q    <= 1'b0;
      digits_q    <= '0;
      count_q     <= '0;
      tmr_q       <= '0;
      commit_q    <= '0;
      set_time_q  <= 1'b0;
      set_alarm_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      target_q    <= target_d;
      digits_q    <= digits_d;
      count_q     <= count_d;
      tmr_q       <= tmr_d;
      commit_q    <= commit_d;
      set_time_q  <= set_time_d;
      set_alarm_q <= set_alarm_d;
      err_q       <= err_d;
    end
  end

  assign bus.entry_active = (state_q == ENTRY);
  assign bus.entry_target = target_q;
  assign bus.entry_digits = digits_q;
  assign bus.entry_count  = count_q;
  assign bus.set_time     = set_time_q;
  assign bus.set_alarm    = set_alarm_q;
  assign bus.commit_hhmm  = commit_q;
  assign bus.entry_err    = err_q;
endmodule

// File: tb/tb_time_entry_fsm.sv
// Directed bench for time_entry_fsm: commits, range rejects, backspace, retarget,
// timeout and mid-entry reset, each checked against hand-computed values.
module tb_time_entry_fsm;
  logic clk;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  logic pulse_seen;

  time_entry_fsm_if bus ();

  time_entry_fsm #(.TIMEOUT_CYCLES(100), .TMR_W(30)) dut (
    .CLK100MHZ (clk),
    .reset     (reset),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; key is sampled on the following posedge and the
  // task returns at the next negedge, where the key's effect is visible.
  task automatic press(input logic [3:0] code);
    bus.key_code  = code;
    bus.key_valid = 1'b1;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'h0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.key_code  = 4'h0;
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_active", bus.entry_active, 0);
    chk("rst_digits", bus.entry_digits, 0);
    chk("rst_count",  bus.entry_count,  0);
    chk("rst_commit", bus.commit_hhmm,  0);
    chk("rst_pulses", {bus.set_time, bus.set_alarm, bus.entry_err}, 0);
    reset = 1'b0;
    step();

    // 1: time commit 12:34
    press(4'hB);
    chk("t1_active", bus.entry_active, 1);
    chk("t1_target", bus.entry_target, 0);
    press(4'h1); press(4'h2); press(4'h3); press(4'h4);
    chk("t1_digits", bus.entry_digits, 16'h1234);
    chk("t1_count",  bus.entry_count,  4);
    press(4'hE);
    chk("t1_set_time",  bus.set_time,    1);
    chk("t1_set_alarm", bus.set_alarm,   0);
    chk("t1_commit",    bus.commit_hhmm, 16'h1234);
    step();
    chk("t1_pulse_len", bus.set_time,     0);
    chk("t1_idle",      bus.entry_active, 0);
    chk("t1_clr_cnt",   bus.entry_count,  0);
    chk("t1_clr_dig",   bus.entry_digits, 0);
    chk("t1_hold",      bus.commit_hhmm,  16'h1234);

    // 2: alarm with p1 range depending on p0==2
    press(4'hA);
    chk("t2_target", bus.entry_target, 1);
    press(4'h2);
    press(4'h4);
    chk("t2_err",    bus.entry_err,    1);
    chk("t2_count",  bus.entry_count,  1);
    chk("t2_digits", bus.entry_digits, 16'h2000);
    step();
    chk("t2_err_len", bus.entry_err, 0);
    press(4'h3); press(4'h5); press(4'h9);
    press(4'hE);
    chk("t2_set_alarm", bus.set_alarm,   1);
    chk("t2_set_time",  bus.set_time,    0);
    chk("t2_commit",    bus.commit_hhmm, 16'h2359);

    // 3: backspace down to cancel
    press(4'hB);
    press(4'h1); press(4'h7);
    chk("t3_digits0", bus.entry_digits, 16'h1700);
    press(4'hD);
    chk("t3_cnt1", bus.entry_count,  1);
    chk("t3_dig1", bus.entry_digits, 16'h1000);
    press(4'hD);
    chk("t3_cnt0", bus.entry_count,  0);
    chk("t3_dig0", bus.entry_digits, 16'h0000);
    chk("t3_still", bus.entry_active, 1);
    press(4'hD);
    chk("t3_cancel", bus.entry_active, 0);
    chk("t3_pulses", {bus.set_time, bus.set_alarm, bus.entry_err}, 0);
    chk("t3_commit", bus.commit_hhmm, 16'h2359);

    // 3b: backspace p0 then re-enter re-evaluates p1
    press(4'hB);
    press(4'h1); press(4'h8);
    press(4'hD); press(4'hD);
    press(4'h2); press(4'h8);
    chk("t3b_err",   bus.entry_err,    1);
    chk("t3b_count", bus.entry_count,  1);
    press(4'h0); press(4'h0); press(4'h0);
    press(4'h1);
    chk("t3b_full_err", bus.entry_err,    1);
    chk("t3b_digits",   bus.entry_digits, 16'h2000);
    press(4'hD); press(4'hD); press(4'hD); press(4'hD); press(4'hD);
    chk("t3b_cancel", bus.entry_active, 0);

    // 4: early enter, then retarget
    press(4'hB);
    press(4'h0); press(4'h9);
    press(4'hE);
    chk("t4_err",    bus.entry_err,    1);
    chk("t4_active", bus.entry_active, 1);
    chk("t4_count",  bus.entry_count,  2);
    chk("t4_digits", bus.entry_digits, 16'h0900);
    chk("t4_noset",  {bus.set_time, bus.set_alarm}, 0);
    press(4'hF);
    chk("t4_f_noerr", bus.entry_err, 0);
    press(4'hA);
    chk("t4_target", bus.entry_target, 1);
    chk("t4_count0", bus.entry_count,  0);
    chk("t4_dig0",   bus.entry_digits, 0);
    press(4'hD);
    chk("t4_cancel", bus.entry_active, 0);

    // 5: timeout after 100 idle cycles
    press(4'hB);
    press(4'h1);
    pulse_seen = 1'b0;
    repeat (99) begin
      step();
      pulse_seen |= bus.set_time | bus.set_alarm | bus.entry_err;
    end
    chk("t5_before", bus.entry_active, 1);
    step();
    chk("t5_expired", bus.entry_active, 0);
    chk("t5_cleared", {bus.entry_count, bus.entry_digits}, 0);
    chk("t5_nopulse", {pulse_seen, bus.entry_err}, 0);

    // 5b: key on the expiry cycle is taken and restarts the timer
    press(4'hB);
    press(4'h1);
    repeat (99) step();
    press(4'h2);
    chk("t5b_active", bus.entry_active, 1);
    chk("t5b_count",  bus.entry_count,  2);
    chk("t5b_digits", bus.entry_digits, 16'h1200);
    repeat (99) step();
    chk("t5b_before", bus.entry_active, 1);
    step();
    chk("t5b_expired", bus.entry_active, 0);

    // 6: reset mid-entry discards the buffer
    press(4'hB);
    press(4'h1); press(4'h2); press(4'h3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    press(4'hE);
    chk("t6_idle",   bus.entry_active, 0);
    chk("t6_noset",  {bus.set_time, bus.set_alarm, bus.entry_err}, 0);
    chk("t6_commit", bus.commit_hhmm, 0);
    chk("t6_count",  bus.entry_count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog");
  end
endmodule
